// File: rtl/qspa_pkg.sv
// Shared types and constants for the QSP instruction path.
// No logic; constants only.
// Imported by the IQ0 queue and its storage array.
package qspa_pkg;

  localparam int INSTR_WIDTH = 32;

  // The decoder treats an all-zero word as a no-write bubble.
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/qsp_iq_mem.sv
// Storage array for the IQ0 instruction queue: one synchronous write port and one combinational read port.
// Latency: a write lands on the clock edge; a read is combinational from rd_addr.
// Backpressure: none here; the parent only writes when it has accepted a push.
module qsp_iq_mem
  import qspa_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [PTR_W-1:0]       wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]       rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  // Write the accepted instruction. The array has no reset because the pointers and count mark what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qsp_iq.sv
// IQ0 instruction queue feeding QSP decode. Optional high-water mark output under macro QSP_IQ_HWM_EN.
// Latency: a word pushed on edge k reaches the registered instr_out on edge k+1 if the queue was empty and there is no stall.
// Backpressure: push_ready drops when full, during flush or reset; stall freezes the output but pushes are still accepted.
module qsp_iq
  import qspa_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  output logic                   push_ready,
  input  logic                   stall,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic [CNT_W-1:0]       count,
`ifdef QSP_IQ_HWM_EN
  output logic [CNT_W-1:0]       hwm,
`endif
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   do_push;
  logic                   do_pop;
  logic [CNT_W-1:0]       count_nxt;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = !full && !flush && !rst;

  qsp_iq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (push_instr),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Decide push and pop for this cycle, and compute the occupancy after the edge. Flush empties the queue.
  always_comb begin
    do_push   = push_valid && push_ready;
    do_pop    = !stall && !flush && !empty;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Update the pointers, the count and the decode-facing output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      // With no stall, the output takes the oldest entry, or a bubble when the queue is empty.
      if (!stall) begin
        instr_out   <= do_pop ? rd_data : NOP_INSTR;
        instr_valid <= do_pop;
      end
    end
  end

`ifdef QSP_IQ_HWM_EN
  // Track peak occupancy. Only reset clears it, so it records the peak across flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm <= '0;
    end else if (count_nxt > hwm) begin
      hwm <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_qsp_iq.sv
// Directed self-checking bench for qsp_iq with DEPTH = 4.
// Drives and samples 1 time unit after each rising edge.
// Covers reset, streaming, full/stall, flush, wrap and asynchronous reset.
module tb_qsp_iq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [31:0] push_instr = '0;
  logic        push_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef QSP_IQ_HWM_EN
  logic [2:0]  hwm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qsp_iq #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_instr  (push_instr),
    .push_ready  (push_ready),
    .stall       (stall),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .count       (count),
`ifdef QSP_IQ_HWM_EN
    .hwm         (hwm),
`endif
    .full        (full),
    .empty       (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp_instr, input logic exp_vld,
                         input logic [2:0] exp_cnt);
    chk({tag, "_instr"}, instr_out, exp_instr);
    chk({tag, "_vld"}, {31'd0, instr_valid}, {31'd0, exp_vld});
    chk({tag, "_cnt"}, {29'd0, count}, {29'd0, exp_cnt});
  endtask

  initial begin
    // 1: reset state, then an idle cycle
    #3;
    chk_out("rst", 32'h0, 1'b0, 3'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_rdy", {31'd0, push_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_rdy", {31'd0, push_ready}, 32'd1);
    tick();
    chk_out("idle", 32'h0, 1'b0, 3'd0);
    chk("idle_empty", {31'd0, empty}, 32'd1);

    // 2: three back-to-back pushes with no stall
    push_valid = 1'b1; push_instr = 32'h1111_1111;
    tick();
    chk_out("s2_e1", 32'h0, 1'b0, 3'd1);
    push_instr = 32'h2222_2222;
    tick();
    chk_out("s2_e2", 32'h1111_1111, 1'b1, 3'd1);
    push_instr = 32'h3333_3333;
    tick();
    chk_out("s2_e3", 32'h2222_2222, 1'b1, 3'd1);
    push_valid = 1'b0;
    tick();
    chk_out("s2_e4", 32'h3333_3333, 1'b1, 3'd0);
    tick();
    chk_out("s2_bub", 32'h0, 1'b0, 3'd0);

    // 3: stall while pushing five words; the fifth is held off until a pop frees space
    stall = 1'b1; push_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_instr = 32'hA0 + i;
      tick();
      chk("s3_fill_cnt", {29'd0, count}, i + 1);
    end
    push_instr = 32'hA4;
    chk("s3_full", {31'd0, full}, 32'd1);
    chk("s3_rdy0", {31'd0, push_ready}, 32'd0);
    chk_out("s3_hold", 32'h0, 1'b0, 3'd4);
    tick();
    chk_out("s3_blocked", 32'h0, 1'b0, 3'd4);
    stall = 1'b0;
    tick();
    chk_out("s3_p0", 32'hA0, 1'b1, 3'd3);
    chk("s3_rdy1", {31'd0, push_ready}, 32'd1);
    tick();
    chk_out("s3_p1", 32'hA1, 1'b1, 3'd3);
    push_valid = 1'b0;
    tick();
    chk_out("s3_p2", 32'hA2, 1'b1, 3'd2);
    tick();
    chk_out("s3_p3", 32'hA3, 1'b1, 3'd1);
    tick();
    chk_out("s3_p4", 32'hA4, 1'b1, 3'd0);
`ifdef QSP_IQ_HWM_EN
    chk("s3_hwm", {29'd0, hwm}, 32'd4);
`endif

    // 4: flush with stall and push both asserted, two entries queued
    stall = 1'b1; push_valid = 1'b1;
    push_instr = 32'hB0; tick();
    push_instr = 32'hB1; tick();
    chk_out("s4_pre", 32'hA4, 1'b1, 3'd2);
    flush = 1'b1; push_instr = 32'hDEAD_BEEF;
    #1;
    chk("s4_rdy", {31'd0, push_ready}, 32'd0);
    tick();
    chk_out("s4_flush", 32'h0, 1'b0, 3'd0);
    chk("s4_empty", {31'd0, empty}, 32'd1);
    flush = 1'b0; stall = 1'b0; push_valid = 1'b0;
    tick();
    chk_out("s4_after", 32'h0, 1'b0, 3'd0);

    // 5: steady push and pop with pointer wrap
    push_valid = 1'b1; push_instr = 32'hC000_0000;
    tick();
    for (int i = 1; i <= 10; i++) begin
      push_instr = 32'hC000_0000 + i;
      tick();
      chk_out("s5_stream", 32'hC000_0000 + i - 1, 1'b1, 3'd1);
    end
    push_valid = 1'b0;
    tick();
    chk_out("s5_last", 32'hC000_000A, 1'b1, 3'd0);

    // 6: asynchronous reset mid-stream with three entries queued
    stall = 1'b1; push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_instr = 32'hD0 + i;
      tick();
    end
    push_valid = 1'b0;
    chk_out("s6_pre", 32'hC000_000A, 1'b1, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_out("s6_arst", 32'h0, 1'b0, 3'd0);
    chk("s6_empty", {31'd0, empty}, 32'd1);
    chk("s6_rdy", {31'd0, push_ready}, 32'd0);
`ifdef QSP_IQ_HWM_EN
    chk("s6_hwm", {29'd0, hwm}, 32'd0);
`endif
    tick();
    rst = 1'b0; stall = 1'b0;
    tick();
    chk_out("s6_post", 32'h0, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qsp_iq.md
Name: qsp_iq

Overview:
- IQ0 instruction queue directly upstream of the QSP core.
- Buffers 32-bit instructions pushed by the fetch/host side behind a valid/ready handshake.
- Presents one instruction per cycle on a registered output that feeds the core decode stage.
- When the queue is empty it issues NOP_INSTR bubbles. It honours stall (hold) and flush (discard everything).

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two and >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- push_valid  in  1  producer has an instruction on push_instr
- push_instr  in  32  instruction to enqueue
- push_ready  out  1  queue accepts push_instr this cycle
- stall  in  1  core cannot take a new instruction; output holds
- flush  in  1  synchronous discard of queue contents and output
- instr_out  out  32  instruction presented to core decode (registered)
- instr_valid  out  1  instr_out holds a real queued instruction (0 means bubble)
- count  out  CNT_W  current number of stored entries, excluding instr_out
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - write and read pointers = 0, count = 0
  - instr_out = NOP_INSTR, instr_valid = 0
  - push_ready = 0, full = 0, empty = 1
- Storage is a circular buffer of DEPTH x 32. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- push_ready = !full && !flush && !rst. It is combinational from state and never depends on push_valid.
- A push occurs when push_valid && push_ready. The entry is written at wr_ptr and wr_ptr increments.
- A pop occurs when !stall && !flush && !empty:
  - instr_out <= mem[rd_ptr], instr_valid <= 1, rd_ptr increments.
- When !stall && !flush && empty: instr_out <= NOP_INSTR, instr_valid <= 0. This is a bubble; pointers do not change.
- When stall && !flush: instr_out and instr_valid hold their values and no pop occurs. Pushes are still accepted.
- Count update: +1 on push only, -1 on pop only, unchanged when a push and a pop occur in the same cycle.
- Full: push_ready = 0, so no push is possible even if a pop occurs in the same cycle (no pass-through when full).
- Empty with a push: the entry is written this edge. It is not bypassed to the output; it pops on the following non-stalled edge.
- Latency: an instruction accepted on edge k appears on instr_out after edge k+1, provided stall is low at edge k+1 and nothing older is queued.
- Ordering is strictly FIFO; there is no reordering or drop.
- Flush has priority over both stall and push:
  - pointers and count go to 0
  - instr_out <= NOP_INSTR, instr_valid <= 0
  - any push in that cycle is ignored (push_ready is already 0)
- Reset asserted mid-operation clears all state immediately. After rst deasserts, the first edge is a normal cycle with the queue empty.
- full and empty are decoded combinationally from count.

Optional Feature:
- Macro: QSP_IQ_HWM_EN.
- When defined:
  - adds output port hwm (width CNT_W), the high-water mark
  - hwm <= max(hwm, next count) on every edge
  - hwm clears to 0 on rst only; it is NOT cleared by flush
- When undefined: no hwm port and no extra registers. All other behaviour is identical.

Decomposition:
- In qspa_pkg:
  - INSTR_WIDTH = 32
  - NOP_INSTR = 32'h0000_0000, which the decoder treats as no-write
- One sub-module: qsp_iq_mem.
  - DEPTH x INSTR_WIDTH array with one synchronous write port and one combinational read port.
  - It has no reset on the array.
- Pointer, count and output-register logic live in qsp_iq.

Test Plan:
All scenarios use DEPTH = 4.
1. Reset then idle, stall = 0 -> instr_out = 0x00000000, instr_valid = 0, count = 0, empty = 1, push_ready = 1 after rst falls.
2. Push 0x11111111, 0x22222222, 0x33333333 back-to-back, stall = 0 -> instr_out shows 0x11111111 / 0x22222222 / 0x33333333 with instr_valid = 1 on the 2nd/3rd/4th edges after the first push, followed by a bubble.
3. stall = 1 with 5 pushes 0xA0..0xA4 -> 4 pushes accepted, full = 1, push_ready = 0, 0xA4 held off. Release stall -> outputs 0xA0..0xA3 in order, then 0xA4 is accepted once push_ready rises.
4. Queue holding 2 entries, flush asserted together with stall = 1 and push_valid = 1 -> next cycle count = 0, instr_valid = 0, instr_out = NOP_INSTR, pushed word discarded.
5. Steady push + pop every cycle for 10 cycles (wrap twice) -> count constant at 1, output sequence matches input with no gaps.
6. rst pulsed asynchronously mid-stream with 3 entries queued -> outputs return to reset values immediately without waiting for a clock edge. With QSP_IQ_HWM_EN, hwm reads 4 after scenario 3 and 0 after rst.
